// File: rtl/joystick_pkg.sv
// Shared constants and types for the joystick conditioner.
// Bit order inside one channel: {fire, left, right, down, up} at offsets 0..4.
package joystick_pkg;
  localparam int JOY_FIRE  = 0;
  localparam int JOY_LEFT  = 1;
  localparam int JOY_RIGHT = 2;
  localparam int JOY_DOWN  = 3;
  localparam int JOY_UP    = 4;
  localparam int JOY_BITS  = 5;

  typedef enum logic {AF_IDLE, AF_RUN} af_state_t;
endpackage

// File: rtl/joystick_debounce_bit.sv
// One joystick pin: 2-FF synchroniser, polarity normalisation (1 = pressed)
// and a tick-driven debounce counter.
module joystick_debounce_bit #(
  parameter bit ACTIVE_LOW     = 1'b1,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pin,
  input  logic i_tick,
  output logic o_level
);
  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic [CW-1:0] r_cnt;
  logic          w_sample;

  assign w_sample = r_sync2 ^ ACTIVE_LOW;
  assign o_level  = r_level;

  // Sync FFs reset to the idle pin level so reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= ACTIVE_LOW;
      r_sync2 <= ACTIVE_LOW;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_pin;
      r_sync2 <= r_sync1;
      if (i_tick) begin
        if (w_sample == r_level) begin
          r_cnt <= '0;
        end else if (r_cnt == CW'(DEBOUNCE_TICKS - 1)) begin
          r_level <= w_sample;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end
endmodule

// File: rtl/joystick_conditioner.sv
// Joystick conditioner top: prescaler, per-bit debounce, opposing-direction
// suppression, optional autofire (macro JOYSTICK_AUTOFIRE_EN) and output register.
module joystick_conditioner
  import joystick_pkg::*;
#(
  parameter int CHANNELS       = 2,
  parameter bit ACTIVE_LOW     = 1'b1,
  parameter int TICK_DIV       = 1000,
  parameter int DEBOUNCE_TICKS = 4,
  parameter int AUTOFIRE_TICKS = 5000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [0:JOY_BITS*CHANNELS-1] pin_in,
  input  logic [0:CHANNELS-1]          autofire_req,
  output logic [0:JOY_BITS*CHANNELS-1] joy_out,
  output logic                         change
);
  localparam int NB = JOY_BITS * CHANNELS;
  localparam int PW = $clog2(TICK_DIV);

  logic [PW-1:0]       r_presc;
  logic                w_tick;
  logic [0:NB-1]       w_deb;
  logic [0:CHANNELS-1] w_fire;
  logic [0:NB-1]       w_next;
  logic [0:NB-1]       r_joy;
  logic                r_change;

  assign w_tick = (r_presc == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_presc <= '0;
    else if (w_tick) r_presc <= '0;
    else             r_presc <= r_presc + PW'(1);
  end

  for (genvar i = 0; i < NB; i++) begin : g_bit
    joystick_debounce_bit #(
      .ACTIVE_LOW     (ACTIVE_LOW),
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
    ) u_db (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_pin   (pin_in[i]),
      .i_tick  (w_tick),
      .o_level (w_deb[i])
    );
  end

`ifdef JOYSTICK_AUTOFIRE_EN
  localparam int AW = $clog2(AUTOFIRE_TICKS + 1);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_af
    af_state_t     r_state;
    logic          r_phase;
    logic [AW-1:0] r_cnt;
    logic          w_deb_fire;

    assign w_deb_fire = w_deb[c*JOY_BITS+JOY_FIRE];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= AF_IDLE;
        r_phase <= 1'b0;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          AF_IDLE: begin
            if (w_deb_fire && autofire_req[c]) begin
              r_state <= AF_RUN;
              r_phase <= 1'b1;
              r_cnt   <= '0;
            end
          end
          AF_RUN: begin
            if (!w_deb_fire || !autofire_req[c]) begin
              r_state <= AF_IDLE;
              r_phase <= 1'b0;
              r_cnt   <= '0;
            end else if (w_tick) begin
              if (r_cnt == AW'(AUTOFIRE_TICKS - 1)) begin
                r_cnt   <= '0;
                r_phase <= ~r_phase;
              end else begin
                r_cnt <= r_cnt + AW'(1);
              end
            end
          end
          default: begin
            r_state <= AF_IDLE;
            r_phase <= 1'b0;
            r_cnt   <= '0;
          end
        endcase
      end
    end

    // Gating with the debounced level drops fire immediately on release.
    assign w_fire[c] = w_deb_fire &
                       (((r_state == AF_RUN) && autofire_req[c]) ? r_phase : 1'b1);
  end
`else
  logic w_unused_autofire_req;
  assign w_unused_autofire_req = ^autofire_req;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_fire
    assign w_fire[c] = w_deb[c*JOY_BITS+JOY_FIRE];
  end
`endif

  always_comb begin
    w_next = w_deb;
    for (int c = 0; c < CHANNELS; c++) begin
      w_next[c*JOY_BITS+JOY_FIRE] = w_fire[c];
      if (w_deb[c*JOY_BITS+JOY_LEFT] && w_deb[c*JOY_BITS+JOY_RIGHT]) begin
        w_next[c*JOY_BITS+JOY_LEFT]  = 1'b0;
        w_next[c*JOY_BITS+JOY_RIGHT] = 1'b0;
      end
      if (w_deb[c*JOY_BITS+JOY_UP] && w_deb[c*JOY_BITS+JOY_DOWN]) begin
        w_next[c*JOY_BITS+JOY_UP]   = 1'b0;
        w_next[c*JOY_BITS+JOY_DOWN] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_joy    <= '0;
      r_change <= 1'b0;
    end else begin
      r_joy    <= w_next;
      r_change <= (w_next != r_joy);
    end
  end

  assign joy_out = r_joy;
  assign change  = r_change;
endmodule

// File: tb/tb_joystick_conditioner.sv
// Directed bench for joystick_conditioner: TICK_DIV=4, DEBOUNCE_TICKS=3,
// AUTOFIRE_TICKS=2, two active-low channels.
module tb_joystick_conditioner;
  localparam int NB = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [0:NB-1] pin_in = '1;
  logic [0:1]    autofire_req = '0;
  logic [0:NB-1] joy_out;
  logic          change;

  int n_checks = 0;
  int n_errors = 0;
  int change_cnt = 0;

  joystick_conditioner #(
    .CHANNELS       (2),
    .ACTIVE_LOW     (1'b1),
    .TICK_DIV       (4),
    .DEBOUNCE_TICKS (3),
    .AUTOFIRE_TICKS (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pin_in       (pin_in),
    .autofire_req (autofire_req),
    .joy_out      (joy_out),
    .change       (change)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (change === 1'b1) change_cnt++;

  task automatic wait_bit(input int idx, input logic val, output int lat);
    lat = 0;
    while (joy_out[idx] !== val && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic measure_run(input logic val, output int n);
    n = 0;
    while (joy_out[0] === val && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic check_latency(input string name, input int lat);
    n_checks++;
    if (lat < 12 || lat > 15) begin
      n_errors++;
      $display("FAIL %s: latency %0d cycles, required 12..15", name, lat);
    end
  endtask

  task automatic wait_idle();
    int n;
    pin_in = '1;
    autofire_req = '0;
    n = 0;
    while (joy_out !== '0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n >= 60) begin
      n_errors++;
      $display("FAIL idle_timeout: joy_out=%b, required all 0", joy_out);
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (joy_out !== '0 || change !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state: joy_out=%b change=%b, required 0/0", joy_out, change);
    end
    rst_n = 1'b1;
    change_cnt = 0;
    repeat (100) @(negedge clk);
    n_checks++;
    if (joy_out !== '0 || change_cnt != 0) begin
      n_errors++;
      $display("FAIL idle_100: joy_out=%b changes=%0d, required 0/0", joy_out, change_cnt);
    end
  endtask

  task automatic test_press();
    int lat;
    logic [0:NB-1] e;
    e = '0;
    e[4] = 1'b1;
    change_cnt = 0;
    pin_in[4] = 1'b0;
    wait_bit(4, 1'b1, lat);
    check_latency("press_latency", lat);
    n_checks++;
    if (joy_out !== e) begin
      n_errors++;
      $display("FAIL press_value: joy_out=%b, required %b", joy_out, e);
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if (change_cnt != 1) begin
      n_errors++;
      $display("FAIL press_change: %0d pulses, required 1", change_cnt);
    end
    change_cnt = 0;
    pin_in[4] = 1'b1;
    wait_bit(4, 1'b0, lat);
    check_latency("release_latency", lat);
    repeat (5) @(negedge clk);
    n_checks++;
    if (change_cnt != 1 || joy_out !== '0) begin
      n_errors++;
      $display("FAIL release_change: %0d pulses joy_out=%b, required 1 and 0", change_cnt, joy_out);
    end
  endtask

  task automatic test_glitch();
    change_cnt = 0;
    pin_in[4] = 1'b0;
    repeat (6) @(negedge clk);
    pin_in[4] = 1'b1;
    repeat (30) @(negedge clk);
    n_checks++;
    if (joy_out !== '0 || change_cnt != 0) begin
      n_errors++;
      $display("FAIL glitch: joy_out=%b changes=%0d, required 0/0", joy_out, change_cnt);
    end
  endtask

  task automatic test_opposing();
    int lat;
    int bad;
    logic [0:NB-1] e;
    change_cnt = 0;
    bad = 0;
    pin_in[6] = 1'b0;
    pin_in[7] = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (joy_out !== '0) bad++;
    end
    n_checks++;
    if (bad != 0 || change_cnt != 0) begin
      n_errors++;
      $display("FAIL opposing_lr: %0d bad cycles, %0d changes, required 0/0", bad, change_cnt);
    end
    pin_in[7] = 1'b1;
    wait_bit(6, 1'b1, lat);
    check_latency("opposing_release", lat);
    e = '0;
    e[6] = 1'b1;
    n_checks++;
    if (joy_out !== e) begin
      n_errors++;
      $display("FAIL opposing_left: joy_out=%b, required %b", joy_out, e);
    end
    wait_idle();
  endtask

  task automatic test_autofire();
    int lat;
    int n;
    int bad;
    logic exp_v;
    autofire_req[0] = 1'b1;
    pin_in[0] = 1'b0;
    wait_bit(0, 1'b1, lat);
    check_latency("af_rise", lat);
`ifdef JOYSTICK_AUTOFIRE_EN
    measure_run(1'b1, n);
    n_checks++;
    if (n != 8) begin n_errors++; $display("FAIL af_high1: %0d cycles, required 8", n); end
    measure_run(1'b0, n);
    n_checks++;
    if (n != 8) begin n_errors++; $display("FAIL af_low1: %0d cycles, required 8", n); end
    measure_run(1'b1, n);
    n_checks++;
    if (n != 8) begin n_errors++; $display("FAIL af_high2: %0d cycles, required 8", n); end
    // Release at the start of a low phase; debounced release lands mid-high.
    pin_in[0] = 1'b1;
    for (int i = 1; i <= 31; i++) begin
      @(negedge clk);
      exp_v = (i >= 8 && i <= 11);
      n_checks++;
      if (joy_out[0] !== exp_v) begin
        n_errors++;
        $display("FAIL af_release c%0d: fire=%b, required %b", i, joy_out[0], exp_v);
      end
    end
    wait_idle();
    autofire_req[0] = 1'b1;
    pin_in[0] = 1'b0;
    wait_bit(0, 1'b1, lat);
    measure_run(1'b1, n);
    repeat (2) @(negedge clk);
    n_checks++;
    if (joy_out[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL af_low_before_drop: fire=%b, required 0", joy_out[0]);
    end
    autofire_req[0] = 1'b0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (joy_out[0] !== 1'b1) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_errors++;
      $display("FAIL af_req_drop: %0d cycles not pressed, required 0", bad);
    end
`else
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (joy_out[0] !== 1'b1) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_errors++;
      $display("FAIL af_disabled_steady: %0d cycles not pressed, required 0", bad);
    end
    pin_in[0] = 1'b1;
    wait_bit(0, 1'b0, lat);
    check_latency("af_disabled_release", lat);
`endif
    wait_idle();
  endtask

  task automatic test_async_reset();
    int lat;
    logic [0:NB-1] e;
    logic [0:NB-1] exp_v;
    pin_in[4] = 1'b0;
    wait_bit(4, 1'b1, lat);
    check_latency("pre_reset_press", lat);
    pin_in[9] = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (joy_out !== '0 || change !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reset: joy_out=%b change=%b, required 0/0", joy_out, change);
    end
    @(negedge clk);
    rst_n = 1'b1;
    change_cnt = 0;
    e = '0;
    e[4] = 1'b1;
    e[9] = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      exp_v = (i >= 13) ? e : '0;
      n_checks++;
      if (joy_out !== exp_v) begin
        n_errors++;
        $display("FAIL post_reset c%0d: joy_out=%b, required %b", i, joy_out, exp_v);
      end
    end
    n_checks++;
    if (change_cnt != 1) begin
      n_errors++;
      $display("FAIL post_reset_change: %0d pulses, required 1", change_cnt);
    end
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_press();
    test_glitch();
    test_opposing();
    test_autofire();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
